instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC register, next-PC selection and registered instruction/exception.
// Optional one-entry sequential prefetch register enabled by defining IF_PREFETCH_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              branch_target,
  input  logic                     branch_taken,
  input  logic                     jump_taken,
  input  logic [31:0]              jump_target,
  input  logic                     interrupt_taken,
  input  logic [31:0]              interrupt_vector,
  input  logic                     stall,
  input  logic [32*MEM_WORDS-1:0]  instruction_memory_input,
  output logic [31:0]              pc,
  output logic [31:0]              instruction,
`ifdef IF_PREFETCH_EN
  output logic                     prefetch_valid,
`endif
  output logic                     exception
);

  // MEM_WORDS is a power of two and at least 2, so the index is exactly IDX_W bits.
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic {
    ST_START,
    ST_RUN
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [31:0]         pc_next;
  logic [31:0]         instruction_next;
  logic                exception_next;
  logic                hold;
  logic                sequential;
  logic [IDX_W-1:0]    fetch_index;
  logic [31:0]         fetch_word;
  logic [31:0]         mem_word [MEM_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < MEM_WORDS; gi++) begin : g_unpack
      assign mem_word[gi] = instruction_memory_input[32*gi +: 32];
    end
  endgenerate

  function automatic logic fetch_fault(input logic [1:0] addr_lsb, input logic [31:0] word);
    return (addr_lsb != 2'b00) || (word == 32'hFFFF_FFFF);
  endfunction

  // Next-PC selection; redirects outrank stall, and START ignores all control inputs.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc;
    hold       = 1'b0;
    sequential = 1'b0;
    case (state_reg)
      ST_START: begin
        pc_next    = RESET_PC;
        state_next = ST_RUN;
      end
      default: begin
        if (interrupt_taken) begin
          pc_next = interrupt_vector;
        end else if (jump_taken) begin
          pc_next = jump_target;
        end else if (branch_taken) begin
          pc_next = branch_target;
        end else if (stall) begin
          hold = 1'b1;
        end else begin
          pc_next    = pc + 32'd4;
          sequential = 1'b1;
        end
      end
    endcase
  end

  assign fetch_index = pc_next[IDX_W+1:2];
  assign fetch_word  = mem_word[fetch_index];

`ifdef IF_PREFETCH_EN
  logic [31:0]      prefetch_reg;
  logic             prefetch_valid_reg;
  logic [IDX_W-1:0] prefetch_index;
  logic [31:0]      prefetch_word;
  logic [31:0]      selected_word;

  // Index arithmetic wraps inside the aliased window exactly as next_pc+4 would.
  assign prefetch_index = fetch_index + IDX_W'(1);
  assign prefetch_word  = mem_word[prefetch_index];

  always_comb begin
    selected_word = fetch_word;
    if (sequential && prefetch_valid_reg) begin
      selected_word = prefetch_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefetch_reg       <= 32'h0;
      prefetch_valid_reg <= 1'b0;
    end else if (!hold) begin
      prefetch_reg       <= prefetch_word;
      prefetch_valid_reg <= 1'b1;
    end
  end

  assign prefetch_valid = prefetch_valid_reg;
`else
  logic [31:0] selected_word;
  assign selected_word = fetch_word;
`endif

  assign instruction_next = selected_word;
  assign exception_next   = fetch_fault(pc_next[1:0], selected_word);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_START;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      exception   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (!hold) begin
        pc          <= pc_next;
        instruction <= instruction_next;
        exception   <= exception_next;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus pushes expectations,
// a monitor pops and compares after every clock edge or reset assertion.
module tb_instruction_fetch;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  branch_target = 32'h0;
  logic         branch_taken = 1'b0;
  logic         jump_taken = 1'b0;
  logic [31:0]  jump_target = 32'h0;
  logic         interrupt_taken = 1'b0;
  logic [31:0]  interrupt_vector = 32'h0;
  logic         stall = 1'b0;
  logic [255:0] mem_bus;
  logic [31:0]  pc;
  logic [31:0]  instruction;
  logic         exception;
`ifdef IF_PREFETCH_EN
  logic         prefetch_valid;
`endif

  logic [31:0]  mem [8];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) mem_bus[32*i +: 32] = mem[i];
  end

  instruction_fetch #(.RESET_PC(32'h0), .MEM_WORDS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .branch_target            (branch_target),
    .branch_taken             (branch_taken),
    .jump_taken               (jump_taken),
    .jump_target              (jump_target),
    .interrupt_taken          (interrupt_taken),
    .interrupt_vector         (interrupt_vector),
    .stall                    (stall),
    .instruction_memory_input (mem_bus),
    .pc                       (pc),
    .instruction              (instruction),
`ifdef IF_PREFETCH_EN
    .prefetch_valid           (prefetch_valid),
`endif
    .exception                (exception)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every clock edge or reset assertion consumes one pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("instruction", instruction, e.instr);
        chk("exception", {31'h0, exception}, {31'h0, e.exc});
        $display("txn pc=%h instr=%h exc=%0d (exp %h %h %0d)",
                 pc, instruction, exception, e.pc, e.instr, e.exc);
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] i, input logic x);
    exp_t e;
    e.pc = p;
    e.instr = i;
    e.exc = x;
    return e;
  endfunction

  // Called at a falling edge: drive inputs, queue the expectation for the next rising edge.
  task automatic step(input logic irq, input logic [31:0] iv,
                      input logic jmp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt,
                      input logic stl,
                      input logic [31:0] epc, input logic [31:0] ein, input logic eexc);
    interrupt_taken  = irq;
    interrupt_vector = iv;
    jump_taken       = jmp;
    jump_target      = jt;
    branch_taken     = br;
    branch_target    = bt;
    stall            = stl;
    q.push_back(mk(epc, ein, eexc));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic seq(input logic [31:0] epc, input logic [31:0] ein, input logic eexc);
    step(0, 0, 0, 0, 0, 0, 0, epc, ein, eexc);
  endtask

  task automatic load_default_mem();
    for (int i = 0; i < 8; i++) mem[i] = 32'h10 - i;
  endtask

  initial begin
    load_default_mem();
    #1;
    q.push_back(mk(32'h0, 32'h0, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // START then sequential
    seq(32'h0, 32'h10, 0);
    seq(32'h4, 32'h0F, 0);
    seq(32'h8, 32'h0E, 0);
    // stall two cycles, then release
    step(0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h0E, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h8, 32'h0E, 0);
    seq(32'hC, 32'h0D, 0);
    // redirect priority
    step(0, 0, 0, 0, 1, 32'h20, 0, 32'h20, 32'h10, 0);
    step(0, 0, 1, 32'h40, 1, 32'h20, 0, 32'h40, 32'h10, 0);
    step(1, 32'h60, 1, 32'h40, 1, 32'h20, 1, 32'h60, 32'h10, 0);
    seq(32'h64, 32'h0F, 0);
    // all-ones memory; with prefetch the sequential fetch uses the word captured earlier
    for (int i = 0; i < 8; i++) mem[i] = 32'hFFFF_FFFF;
`ifdef IF_PREFETCH_EN
    seq(32'h68, 32'h0E, 0);
`else
    seq(32'h68, 32'hFFFF_FFFF, 1);
`endif
    load_default_mem();
    // misaligned branch, fetch continues sequentially while still faulting
    step(0, 0, 0, 0, 1, 32'h22, 0, 32'h22, 32'h10, 1);
    seq(32'h26, 32'h0F, 1);
    step(0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 32'h10, 0);
    seq(32'h44, 32'h0F, 0);

    // asynchronous reset mid-run, with redirect/stall driven during START
    q.push_back(mk(32'h0, 32'h0, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1, 32'h80, 1, 32'h40, 1, 32'h20, 1, 32'h0, 32'h10, 0);
    seq(32'h4, 32'h0F, 0);

    // PC wraps modulo 2^32
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h09, 0);
    seq(32'h0, 32'h10, 0);

    // word1 changes under a sequential advance
    mem[1] = 32'h55;
`ifdef IF_PREFETCH_EN
    seq(32'h4, 32'h0F, 0);
`else
    seq(32'h4, 32'h55, 0);
`endif
    step(0, 0, 0, 0, 1, 32'h4, 0, 32'h4, 32'h55, 0);
    load_default_mem();
    seq(32'h8, 32'h0E, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
